coherence_bus_ctrl: RTL and testbench

- Snooping coherence controller sitting between two private L1 data caches and the shared L2.
- Arbitrates round-robin between L1 requests and sequences each transaction: writeback, read miss (BusRd), read-exclusive (BusRdX) or upgrade.
- Drives snoop/invalidate to the non-requesting cache, performs dirty cache-to-cache transfers with L2 update, otherwise fetches from L2.
- Implements the cc modport of coherence_ctrl_if plus clock/reset.

---
 rtl/coherence_bus_ctrl_if.sv | 36 +++
 rtl/coherence_bus_ctrl.sv | 155 +++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/coherence_bus_ctrl_if.sv
// Signal bundle between the coherence controller, the two private L1 caches and the shared L2.
// The cc modport is the controller side; slave is the cache/L2 side.
interface coherence_ctrl_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]       dREN;
  logic [CPUS-1:0]       dWEN;
  logic [CPUS-1:0][31:0] daddr;
  logic [CPUS-1:0][31:0] dstore;
  logic [CPUS-1:0]       dwait;
  logic [CPUS-1:0][31:0] dload;
  logic [CPUS-1:0]       cctrans;
  logic [CPUS-1:0]       ccwrite;
  logic [CPUS-1:0]       cchit;
  logic [CPUS-1:0]       ccdirty;
  logic [CPUS-1:0]       ccwait;
  logic [CPUS-1:0]       ccinv;
  logic [CPUS-1:0]       ccexclusive;
  logic [CPUS-1:0][31:0] ccsnpaddr;
  logic [1:0]            l2state;
  logic [31:0]           l2load;
  logic                  l2REN;
  logic                  l2WEN;
  logic [31:0]           l2addr;
  logic [31:0]           l2store;

  modport cc (
    input  dREN, dWEN, daddr, dstore, cctrans, ccwrite, cchit, ccdirty, l2state, l2load,
    output dwait, dload, ccwait, ccinv, ccexclusive, ccsnpaddr, l2REN, l2WEN, l2addr, l2store
  );

  modport slave (
    output dREN, dWEN, daddr, dstore, cctrans, ccwrite, cchit, ccdirty, l2state, l2load,
    input  dwait, dload, ccwait, ccinv, ccexclusive, ccsnpaddr, l2REN, l2WEN, l2addr, l2store
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-cache snooping coherence controller: round-robin arbitration, then writeback,
// read miss / read-exclusive (L2 fill or dirty cache-to-cache transfer) or upgrade.
module coherence_bus_ctrl #(
  parameter int CPUS            = 2,
  parameter int WORDS_PER_BLOCK = 2
) (
  input logic          CLK,
  input logic          RST,
  coherence_ctrl_if.cc ccif
);
  localparam logic [1:0] L2_ACCESS = 2'd2;
  localparam int         CW        = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {IDLE, WB, SNOOP, DONE, C2C, L2RD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            g;
  logic            last_grant;
  logic            hit;
  logic            o;
  logic            gnt;
  logic            access;
  logic            last_word;
  logic            upgrade;
  logic [CPUS-1:0] req;

  assign o         = ~g;
  assign access    = (ccif.l2state == L2_ACCESS);
  assign last_word = (cnt == LAST_WORD);
  assign req       = (ccif.dREN | ccif.dWEN) & ~ccif.ccwait;
  assign upgrade   = ccif.cctrans[g] & ccif.ccwrite[g] & ~ccif.dREN[g];

  // Round-robin pick; a tie goes to the cache that did not win last time.
  always_comb begin
    if (req == {CPUS{1'b1}}) begin
      gnt = ~last_grant;
    end else if (req[1]) begin
      gnt = 1'b1;
    end else begin
      gnt = 1'b0;
    end
  end

  // Transaction sequencer; the snoop answer is latched so the fill can report exclusivity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      g          <= 1'b0;
      last_grant <= 1'b1;
      hit        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            g     <= gnt;
            state <= ccif.cctrans[gnt] ? SNOOP : WB;
          end
        end
        WB, C2C, L2RD: begin
          if (access) begin
            if (last_word) begin
              cnt        <= '0;
              last_grant <= g;
              state      <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        SNOOP: begin
          hit <= ccif.cchit[o];
          if (upgrade) begin
            state <= DONE;
          end else if (ccif.cchit[o] & ccif.ccdirty[o]) begin
            state <= C2C;
          end else begin
            state <= L2RD;
          end
        end
        DONE: begin
          last_grant <= g;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decoded from the sequencing state; L2 errors simply keep dwait high.
  always_comb begin
    ccif.dwait       = '1;
    ccif.dload       = '0;
    ccif.ccwait      = '0;
    ccif.ccinv       = '0;
    ccif.ccexclusive = '0;
    ccif.ccsnpaddr   = '0;
    ccif.l2REN       = 1'b0;
    ccif.l2WEN       = 1'b0;
    ccif.l2addr      = 32'd0;
    ccif.l2store     = 32'd0;
    case (state)
      WB: begin
        ccif.l2WEN   = 1'b1;
        ccif.l2addr  = ccif.daddr[g];
        ccif.l2store = ccif.dstore[g];
        if (access) begin
          ccif.dwait[g] = 1'b0;
        end else begin
          ccif.dwait[g] = 1'b1;
        end
      end
      SNOOP: begin
        ccif.ccwait[o]    = 1'b1;
        ccif.ccsnpaddr[o] = ccif.daddr[g];
        ccif.ccinv[o]     = ccif.ccwrite[g];
      end
      DONE: begin
        ccif.dwait[g] = 1'b0;
      end
      C2C: begin
        ccif.ccwait[o]    = 1'b1;
        ccif.ccsnpaddr[o] = ccif.daddr[g];
        ccif.ccinv[o]     = ccif.ccwrite[g];
        ccif.dload[g]     = ccif.dstore[o];
        ccif.l2WEN        = 1'b1;
        ccif.l2addr       = ccif.daddr[g];
        ccif.l2store      = ccif.dstore[o];
        if (access) begin
          ccif.dwait[g] = 1'b0;
          ccif.dwait[o] = 1'b0;
        end else begin
          ccif.dwait[g] = 1'b1;
          ccif.dwait[o] = 1'b1;
        end
      end
      L2RD: begin
        ccif.l2REN          = 1'b1;
        ccif.l2addr         = ccif.daddr[g];
        ccif.dload[g]       = ccif.l2load;
        ccif.ccexclusive[g] = ~hit;
        if (access) begin
          ccif.dwait[g] = 1'b0;
        end else begin
          ccif.dwait[g] = 1'b1;
        end
      end
      default: begin
        ccif.dwait = '1;
      end
    endcase
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Random two-cache traffic against a transaction-level model of arbitration, snooping,
// L2 memory contents and per-transaction phase timing.
module tb_coherence_bus_ctrl;
  localparam int CPUS = 2;
  localparam int WPB  = 2;
  localparam logic [1:0] L2_FREE = 2'd0, L2_BUSY = 2'd1, L2_ACCESS = 2'd2, L2_ERROR = 2'd3;
  localparam int K_WB = 0, K_RD = 1, K_RDX = 2, K_UPG = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  coherence_ctrl_if #(.CPUS(CPUS)) bus ();

  coherence_bus_ctrl #(.CPUS(CPUS), .WORDS_PER_BLOCK(WPB)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ccif (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Cache-side transaction state
  bit          active [2];
  int          kind   [2];
  logic [31:0] base   [2];
  int          widx   [2];
  logic [31:0] wdata  [2][2];
  bit          snp_hit[2];
  bit          snp_dirty[2];
  logic [31:0] sup    [2][2];
  int          sidx   [2];

  // Reference model state
  logic [31:0] mem [logic [31:0]];
  bit          busy;
  int          owner;
  int          last;
  int          cyc;
  bit          c2c;
  logic [31:0] exp_data [2];
  int          completed;
  bit          did_reset;
  bit          rst_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic issue(input int i);
    active[i]   = 1'b1;
    kind[i]     = $urandom_range(0, 3);
    base[i]     = 32'h100 * $urandom_range(1, 4);
    widx[i]     = 0;
    wdata[i][0] = $urandom;
    wdata[i][1] = $urandom;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      bus.dREN[i]    = active[i] && (kind[i] == K_RD || kind[i] == K_RDX);
      bus.dWEN[i]    = active[i] && (kind[i] == K_WB || kind[i] == K_UPG);
      bus.cctrans[i] = active[i] && (kind[i] != K_WB);
      bus.ccwrite[i] = active[i] && (kind[i] == K_RDX || kind[i] == K_UPG);
      bus.daddr[i]   = base[i] + 32'(4 * widx[i]);
      bus.cchit[i]   = bus.ccwait[i] && snp_hit[i];
      bus.ccdirty[i] = bus.ccwait[i] && snp_hit[i] && snp_dirty[i];
      bus.dstore[i]  = bus.ccwait[i] ? sup[i][sidx[i] % WPB] : wdata[i][widx[i] % WPB];
    end
  endtask

  task automatic reset_checks(input string t);
    check({t, "_dwait"}, 32'(bus.dwait), 32'd3);
    check({t, "_ccwait"}, 32'(bus.ccwait), 32'd0);
    check({t, "_ccinv"}, 32'(bus.ccinv), 32'd0);
    check({t, "_ccexcl"}, 32'(bus.ccexclusive), 32'd0);
    check({t, "_l2ren"}, 32'(bus.l2REN), 32'd0);
    check({t, "_l2wen"}, 32'(bus.l2WEN), 32'd0);
    check({t, "_l2addr"}, bus.l2addr, 32'd0);
    check({t, "_l2store"}, bus.l2store, 32'd0);
    for (int i = 0; i < 2; i++) begin
      check({t, "_snpaddr"}, bus.ccsnpaddr[i], 32'd0);
      check({t, "_dload"}, bus.dload[i], 32'd0);
    end
  endtask

  task automatic observe();
    logic [1:0]  req;
    int          o;
    bit          rd, wr2, l2act, exp_l2act, exp_snoop, exp_dwp, exp_dwo;
    logic [31:0] a;
    l2act = bus.l2REN | bus.l2WEN;
    if (rst_pending) reset_checks("rst");
    if (!busy) begin
      check("idle_dwait", 32'(bus.dwait), 32'd3);
      check("idle_ccwait", 32'(bus.ccwait), 32'd0);
      check("idle_l2", 32'(l2act), 32'd0);
      req = {active[1], active[0]};
      if (req != 2'b00) begin
        owner = (req == 2'b11) ? 1 - last : (req[1] ? 1 : 0);
        o     = 1 - owner;
        busy  = 1'b1;
        cyc   = 0;
        snp_hit[o]   = 1'($urandom_range(0, 1));
        snp_dirty[o] = 1'($urandom_range(0, 1));
        sup[o][0]    = $urandom;
        sup[o][1]    = $urandom;
        sidx[o]      = 0;
        c2c = (kind[owner] == K_RD || kind[owner] == K_RDX) && snp_hit[o] && snp_dirty[o];
        for (int w = 0; w < WPB; w++)
          exp_data[w] = c2c ? sup[o][w] : mem_rd(base[owner] + 32'(4 * w));
        if (rst_pending) check("first_grant_cpu0", 32'(owner), 32'd0);
      end
      rst_pending = 1'b0;
      return;
    end
    o  = 1 - owner;
    rd = (kind[owner] == K_RD || kind[owner] == K_RDX);
    if (!did_reset && c2c && cyc >= 1 && widx[owner] == 1 && completed >= 10) begin
      // Pull reset in the middle of a dirty transfer; everything pending is abandoned.
      RST = 1'b1;
      did_reset = 1'b1;
      rst_pending = 1'b1;
      busy = 1'b0;
      last = 1;
      for (int i = 0; i < 2; i++) begin
        active[i] = 1'b0;
        widx[i]   = 0;
        sidx[i]   = 0;
      end
      return;
    end
    wr2       = (kind[owner] == K_WB) || c2c;
    exp_l2act = (kind[owner] == K_WB) || (rd && cyc >= 1);
    exp_snoop = (kind[owner] != K_WB) && (cyc == 0 || (c2c && cyc >= 1));
    exp_dwp   = exp_l2act ? (bus.l2state != L2_ACCESS) : !(kind[owner] == K_UPG && cyc == 1);
    exp_dwo   = !(c2c && cyc >= 1 && bus.l2state == L2_ACCESS);
    a         = base[owner] + 32'(4 * widx[owner]);
    check("l2_active", 32'(l2act), 32'(exp_l2act));
    check("ccwait_snooper", 32'(bus.ccwait[o]), 32'(exp_snoop));
    check("ccwait_owner", 32'(bus.ccwait[owner]), 32'd0);
    check("dwait_owner", 32'(bus.dwait[owner]), 32'(exp_dwp));
    check("dwait_snooper", 32'(bus.dwait[o]), 32'(exp_dwo));
    check("ccexcl_owner", 32'(bus.ccexclusive[owner]),
          (rd && !c2c && cyc >= 1) ? 32'(!snp_hit[o]) : 32'd0);
    check("ccexcl_other", 32'(bus.ccexclusive[o]), 32'd0);
    if (exp_snoop) begin
      check("ccsnpaddr", bus.ccsnpaddr[o], a);
      check("ccinv", 32'(bus.ccinv[o]), 32'(kind[owner] == K_RDX || kind[owner] == K_UPG));
    end
    if (exp_l2act) begin
      check("l2addr", bus.l2addr, a);
      check("l2wen", 32'(bus.l2WEN), 32'(wr2));
      if (wr2)
        check("l2store", bus.l2store,
              (kind[owner] == K_WB) ? wdata[owner][widx[owner]] : exp_data[widx[owner]]);
    end
    if (!exp_dwp) begin
      if (rd) begin
        check("dload", bus.dload[owner], exp_data[widx[owner]]);
        if (c2c) begin
          mem[a] = exp_data[widx[owner]];
          sidx[o]++;
        end
      end else if (kind[owner] == K_WB) begin
        mem[a] = wdata[owner][widx[owner]];
      end
      widx[owner]++;
      if (kind[owner] == K_UPG || widx[owner] == WPB) begin
        active[owner] = 1'b0;
        busy          = 1'b0;
        last          = owner;
        completed++;
      end
    end
    cyc++;
  endtask

  task automatic step(input bit allow);
    int r;
    RST = 1'b0;
    if (rst_pending) begin
      issue(0);
      issue(1);
    end else if (allow) begin
      for (int i = 0; i < 2; i++)
        if (!active[i] && $urandom_range(0, 3) == 0) issue(i);
    end
    drive();
    r = $urandom_range(0, 99);
    bus.l2state = (r < 50) ? L2_ACCESS : (r < 75) ? L2_BUSY : (r < 85) ? L2_FREE : L2_ERROR;
    #1;
    bus.l2load = mem_rd(bus.l2addr);
    #1;
    observe();
  endtask

  initial begin
    bus.dREN    = '0;
    bus.dWEN    = '0;
    bus.daddr   = '0;
    bus.dstore  = '0;
    bus.cctrans = '0;
    bus.ccwrite = '0;
    bus.cchit   = '0;
    bus.ccdirty = '0;
    bus.l2state = L2_FREE;
    bus.l2load  = 32'd0;
    for (int i = 0; i < 2; i++) begin
      active[i] = 1'b0;
      kind[i] = K_WB;
      base[i] = 32'd0;
      widx[i] = 0;
      sidx[i] = 0;
      snp_hit[i] = 1'b0;
      snp_dirty[i] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        wdata[i][w] = 32'd0;
        sup[i][w] = 32'd0;
      end
    end
    busy = 1'b0;
    owner = 0;
    last = 1;
    cyc = 0;
    c2c = 1'b0;
    completed = 0;
    did_reset = 1'b0;
    rst_pending = 1'b1;
    repeat (3) @(negedge CLK);
    reset_checks("por");
    for (int n = 0; n < 4000; n++) begin
      @(negedge CLK);
      step(n < 3500);
    end
    for (int n = 0; n < 1000 && (active[0] || active[1] || busy); n++) begin
      @(negedge CLK);
      step(1'b0);
    end
    check("drain_idle", 32'(active[0] || active[1] || busy), 32'd0);
    check("mid_c2c_reset_seen", 32'(did_reset), 32'd1);
    check("enough_traffic", 32'(completed > 100), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
